// File: rtl/sccb_init_sequencer.sv
// SCCB/I2C register-init sequencer: walks a LUT and writes {DEV_ADDR, reg, data} frames.
// Optional NACK retry when SCCB_SEQ_RETRY_EN is defined.
module sccb_init_sequencer #(
  parameter int unsigned CLK_DIV   = 50,
  parameter logic [7:0]  DEV_ADDR  = 8'h42,
  parameter int unsigned LUT_DEPTH = 166,
  parameter int unsigned IDX_W     = 8,
  parameter int unsigned DLY_UNIT  = 50000,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  output logic [IDX_W-1:0] LUT_INDEX,
  input  logic [15:0]      LUT_DATA,
  output logic             SCL,
  output logic             SDA_OE,
  input  logic             SDA_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR,
  output logic [IDX_W-1:0] ERR_INDEX
);

  localparam int unsigned CNT_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
`ifdef SCCB_SEQ_RETRY_EN
  localparam int unsigned RETRY_LIM = MAX_RETRY;
`else
  localparam int unsigned RETRY_LIM = 0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_CHECK, S_DELAY, S_START, S_BYTE, S_ACK,
    S_STOP, S_GAP, S_NEXT, S_FAIL, S_DONE, S_ERR
  } state_t;

  state_t             r_state, w_state;
  logic [IDX_W-1:0]   r_idx, w_idx, r_eidx, w_eidx;
  logic               r_busy, w_busy, r_done, w_done, r_err, w_err;
  logic               r_scl, w_scl, r_sda_oe, w_sda_oe, r_nack, w_nack;
  logic [1:0]         r_q, w_q, r_byte, w_byte;
  logic [2:0]         r_bit, w_bit;
  logic [7:0]         r_reg, w_reg, r_dat, w_dat;
  logic [31:0]        r_dly, w_dly;
  logic [RTY_W-1:0]   r_retry, w_retry;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_tick, w_bus;
  logic [7:0]         w_byte_val;
  logic               w_bit_val;

  assign w_bus  = (r_state == S_START) || (r_state == S_BYTE) || (r_state == S_ACK) ||
                  (r_state == S_STOP)  || (r_state == S_GAP);
  assign w_tick = w_bus && (r_cnt == CNT_W'(CLK_DIV - 1));

  always_comb begin
    case (r_byte)
      2'd0:    w_byte_val = DEV_ADDR;
      2'd1:    w_byte_val = r_reg;
      default: w_byte_val = r_dat;
    endcase
  end
  assign w_bit_val = w_byte_val[3'd7 - r_bit];

  // Quarter-tick counter only runs while the bus is in use, so every frame is tick-aligned.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         r_cnt <= '0;
    else if (!w_bus) r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_eidx   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_scl    <= 1'b1;
      r_sda_oe <= 1'b0;
      r_nack   <= 1'b0;
      r_q      <= '0;
      r_byte   <= '0;
      r_bit    <= '0;
      r_reg    <= '0;
      r_dat    <= '0;
      r_dly    <= '0;
      r_retry  <= '0;
    end else begin
      r_state  <= w_state;
      r_idx    <= w_idx;
      r_eidx   <= w_eidx;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_err    <= w_err;
      r_scl    <= w_scl;
      r_sda_oe <= w_sda_oe;
      r_nack   <= w_nack;
      r_q      <= w_q;
      r_byte   <= w_byte;
      r_bit    <= w_bit;
      r_reg    <= w_reg;
      r_dat    <= w_dat;
      r_dly    <= w_dly;
      r_retry  <= w_retry;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_idx    = r_idx;
    w_eidx   = r_eidx;
    w_busy   = r_busy;
    w_done   = r_done;
    w_err    = r_err;
    w_scl    = r_scl;
    w_sda_oe = r_sda_oe;
    w_nack   = r_nack;
    w_q      = r_q;
    w_byte   = r_byte;
    w_bit    = r_bit;
    w_reg    = r_reg;
    w_dat    = r_dat;
    w_dly    = r_dly;
    w_retry  = r_retry;

    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (START) begin
          w_state = S_FETCH;
          w_idx   = '0;
          w_busy  = 1'b1;
          w_done  = 1'b0;
          w_err   = 1'b0;
          w_retry = '0;
        end
      end
      S_FETCH: w_state = S_CHECK;
      // LUT_DATA lags LUT_INDEX by one cycle, so the entry is captured here rather than in FETCH.
      S_CHECK: begin
        w_reg = LUT_DATA[15:8];
        w_dat = LUT_DATA[7:0];
        if (LUT_DATA[15:8] == 8'hFF) begin
          w_dly   = 32'(LUT_DATA[7:0]) * DLY_UNIT;
          w_state = S_DELAY;
        end else begin
          w_state = S_START;
          w_q     = '0;
          w_byte  = '0;
          w_bit   = '0;
          w_nack  = 1'b0;
        end
      end
      S_DELAY: begin
        if (r_dly == '0) begin
          w_state = S_NEXT;
          w_retry = '0;
        end else begin
          w_dly = r_dly - 1'b1;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_q = r_q + 1'b1;
          if (r_q == 2'd0) begin
            w_sda_oe = 1'b1;
          end else begin
            w_scl   = 1'b0;
            w_q     = '0;
            w_state = S_BYTE;
          end
        end
      end
      S_BYTE: begin
        if (w_tick) begin
          w_q = r_q + 1'b1;
          case (r_q)
            2'd0: w_sda_oe = ~w_bit_val;
            2'd1: w_scl    = 1'b1;
            2'd3: begin
              w_scl = 1'b0;
              w_bit = r_bit + 1'b1;
              if (r_bit == 3'd7) w_state = S_ACK;
            end
            default: ;
          endcase
        end
      end
      S_ACK: begin
        if (w_tick) begin
          w_q = r_q + 1'b1;
          case (r_q)
            2'd0: w_sda_oe = 1'b0;
            2'd1: w_scl    = 1'b1;
            2'd2: w_nack   = SDA_IN;
            default: begin
              w_scl = 1'b0;
              if (r_nack || r_byte == 2'd2) begin
                w_state = S_STOP;
              end else begin
                w_byte  = r_byte + 1'b1;
                w_state = S_BYTE;
              end
            end
          endcase
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_q = r_q + 1'b1;
          case (r_q)
            2'd0: w_sda_oe = 1'b1;
            2'd1: w_scl    = 1'b1;
            default: begin
              w_sda_oe = 1'b0;
              w_q      = '0;
              w_state  = S_GAP;
            end
          endcase
        end
      end
      S_GAP: begin
        if (w_tick) begin
          w_q = r_q + 1'b1;
          if (r_q == 2'd3) begin
            if (!r_nack) begin
              w_state = S_NEXT;
              w_retry = '0;
            end else if (r_retry != RTY_W'(RETRY_LIM)) begin
              w_retry = r_retry + 1'b1;
              w_state = S_START;
              w_q     = '0;
              w_byte  = '0;
              w_bit   = '0;
              w_nack  = 1'b0;
            end else begin
              w_state = S_FAIL;
            end
          end
        end
      end
      S_NEXT: begin
        if (r_idx == IDX_W'(LUT_DEPTH - 1)) begin
          w_state = S_DONE;
          w_done  = 1'b1;
          w_busy  = 1'b0;
        end else begin
          w_idx   = r_idx + 1'b1;
          w_state = S_FETCH;
        end
      end
      S_FAIL: begin
        w_err   = 1'b1;
        w_eidx  = r_idx;
        w_busy  = 1'b0;
        w_state = S_ERR;
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign LUT_INDEX = r_idx;
  assign SCL       = r_scl;
  assign SDA_OE    = r_sda_oe;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign ERROR     = r_err;
  assign ERR_INDEX = r_eidx;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Bench for sccb_init_sequencer: random LUTs and NACK plans, checked against a frame-level model
// and a bus-level SCCB slave/monitor.
module tb_sccb_init_sequencer;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned DLY     = 10;
  localparam int unsigned MAXR    = 3;
`ifdef SCCB_SEQ_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RST, START;
  logic [7:0]  LUT_INDEX, ERR_INDEX;
  logic [15:0] lut_data;
  logic        SCL, SDA_OE, BUSY, DONE, ERROR;
  logic        sda_line, slave_drv;
  logic [15:0] lut [DEPTH];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // expected frames
  logic [7:0] eb [16][3];
  int elen [16], edly [16], pnb [16];
  int exp_nfr;
  bit exp_err;
  int exp_eidx;

  // monitor state
  bit         mon_clr = 1'b0;
  int         nfr, bitpos, nrise, r1;
  int         blen [16], tstart [16], tstop [16], per [16];
  bit         gstop [16];
  bit         in_fr, p_scl, p_sda;
  logic [7:0] cur;
  logic [7:0] gb [16][3];

  sccb_init_sequencer #(
    .CLK_DIV(CLK_DIV), .DEV_ADDR(8'h42), .LUT_DEPTH(DEPTH), .IDX_W(8),
    .DLY_UNIT(DLY), .MAX_RETRY(MAXR)
  ) dut (
    .CLK(clk), .RST(RST), .START(START), .LUT_INDEX(LUT_INDEX), .LUT_DATA(lut_data),
    .SCL(SCL), .SDA_OE(SDA_OE), .SDA_IN(sda_line), .BUSY(BUSY), .DONE(DONE),
    .ERROR(ERROR), .ERR_INDEX(ERR_INDEX)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) lut_data <= lut[LUT_INDEX[1:0]];
  assign sda_line = ~(SDA_OE | slave_drv);

  // Open-drain slave + frame decoder; ACKs unless the plan marks this byte of this frame as NACK.
  always @(negedge clk) begin
    logic s;
    s = ~(SDA_OE | slave_drv);
    if (mon_clr) begin
      nfr = 0; in_fr = 0; bitpos = 0; nrise = 0; slave_drv = 0; p_scl = 1; p_sda = 1;
      for (int i = 0; i < 16; i++) begin blen[i] = 0; gstop[i] = 0; per[i] = 0; end
    end else if (nfr < 16) begin
      if (p_scl && SCL && p_sda && !s) begin
        in_fr = 1; bitpos = 0; nrise = 0; blen[nfr] = 0; tstart[nfr] = cyc;
      end else if (in_fr && p_scl && SCL && !p_sda && s) begin
        in_fr = 0; gstop[nfr] = 1; tstop[nfr] = cyc; nfr++; slave_drv = 0;
      end else if (in_fr && !p_scl && SCL) begin
        if (nrise == 0) r1 = cyc;
        if (nrise == 1) per[nfr] = cyc - r1;
        nrise++;
        if (bitpos < 8) begin cur = {cur[6:0], s}; bitpos++; end
      end else if (in_fr && p_scl && !SCL) begin
        if (bitpos == 8) begin
          slave_drv = (pnb[nfr] != blen[nfr]);
          if (blen[nfr] < 3) gb[nfr][blen[nfr]] = cur;
          blen[nfr]++;
          bitpos = 9;
        end else if (bitpos == 9) begin
          slave_drv = 0; bitpos = 0;
        end
      end
      p_scl = SCL;
      p_sda = s;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame-level model: ne/nb/nc = entry to NACK, byte index NACKed, number of NACKs.
  task automatic build_model(input int ne, input int nb, input int nc);
    int f = 0;
    int pend = 0;
    int a;
    exp_err = 0; exp_eidx = 0;
    for (int i = 0; i < 16; i++) pnb[i] = 3;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (lut[i][15:8] == 8'hFF) begin
        pend += int'(lut[i][7:0]) * DLY;
        continue;
      end
      a = 0;
      while (1) begin
        eb[f][0] = 8'h42; eb[f][1] = lut[i][15:8]; eb[f][2] = lut[i][7:0];
        edly[f] = pend; pend = 0;
        if (i == ne && a < nc) begin
          pnb[f] = nb; elen[f] = nb + 1; a++; f++;
          if (RETRY && a <= int'(MAXR)) continue;
          exp_err = 1; exp_eidx = i;
          break;
        end
        pnb[f] = 3; elen[f] = 3; f++;
        break;
      end
      if (exp_err) break;
    end
    exp_nfr = f;
  endtask

  task automatic pulse_start();
    @(negedge clk) START = 1'b1;
    @(negedge clk) START = 1'b0;
  endtask

  task automatic run_seq(input int ne, input int nb, input int nc, input bit poke);
    int n;
    int gap;
    build_model(ne, nb, nc);
    @(negedge clk) mon_clr = 1'b1;
    @(negedge clk) mon_clr = 1'b0;
    pulse_start();
    check("busy_on_start", BUSY, 1);
    check("done_cleared", DONE, 0);
    check("error_cleared", ERROR, 0);
    check("index_restart", LUT_INDEX, 0);
    n = 0;
    while (BUSY && n < 20000) begin
      @(negedge clk);
      n++;
      if (poke && n == 300) begin START = 1'b1; @(negedge clk); START = 1'b0; n++; end
    end
    check("run_timeout", (n >= 20000), 0);
    repeat (4) @(negedge clk);
    check("frame_count", nfr, exp_nfr);
    for (int f = 0; f < exp_nfr && f < 16; f++) begin
      check($sformatf("f%0d_len", f), blen[f], elen[f]);
      check($sformatf("f%0d_stop", f), gstop[f], 1);
      check($sformatf("f%0d_scl_period", f), per[f], 4 * CLK_DIV);
      for (int b = 0; b < elen[f] && b < blen[f] && b < 3; b++)
        check($sformatf("f%0d_byte%0d", f, b), gb[f][b], eb[f][b]);
      if (f > 0) begin
        gap = tstart[f] - tstop[f-1];
        check($sformatf("f%0d_gap_min", f), (gap >= edly[f]), 1);
        check($sformatf("f%0d_gap_max", f), (gap <= edly[f] + 40), 1);
      end
    end
    check("busy_end", BUSY, 0);
    check("done_end", DONE, !exp_err);
    check("error_end", ERROR, exp_err);
    if (exp_err) check("err_index", ERR_INDEX, exp_eidx);
    check("index_end", LUT_INDEX, exp_err ? exp_eidx : DEPTH - 1);
    check("scl_idle", SCL, 1);
    check("sda_idle", SDA_OE, 0);
  endtask

  task automatic rand_lut(input bit allow_dly);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (allow_dly && $urandom_range(0, 3) == 0)
        lut[i] = {8'hFF, 6'd0, 2'($urandom_range(0, 3))};
      else
        lut[i] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
    end
  endtask

  initial begin
    int n;
    RST = 1'b1; START = 1'b0;
    rand_lut(0);
    pnb = '{default: 3};
    mon_clr = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_scl", SCL, 1);
    check("rst_sda_oe", SDA_OE, 0);
    check("rst_index", LUT_INDEX, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_error", ERROR, 0);
    check("rst_err_index", ERR_INDEX, 0);
    RST = 1'b0;
    mon_clr = 1'b0;
    repeat (2) @(negedge clk);

    // all-ACK run with a 10-unit delay entry at index 1; a START while busy must be ignored
    rand_lut(0);
    lut[1] = 16'hFF0A;
    run_seq(-1, 0, 0, 1);

    // reg-addr byte of entry 2 NACKed twice; restarted from DONE
    rand_lut(0);
    run_seq(2, 1, 2, 0);

    // random tables and NACK plans, including a zero-length delay as the last entry
    for (int r = 0; r < 4; r++) begin
      rand_lut(1);
      if (r == 0) lut[DEPTH-1] = 16'hFF00;
      run_seq(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 4)), 0);
    end

    // reset during byte 1 of entry 1, then a full rerun from index 0
    rand_lut(0);
    build_model(-1, 0, 0);
    @(negedge clk) mon_clr = 1'b1;
    @(negedge clk) mon_clr = 1'b0;
    pulse_start();
    n = 0;
    while (!(nfr == 1 && in_fr && blen[1] == 1) && n < 5000) begin @(negedge clk); n++; end
    check("reach_entry1_byte1", (n < 5000), 1);
    RST = 1'b1;
    @(posedge clk); #1;
    check("abort_scl", SCL, 1);
    check("abort_sda_oe", SDA_OE, 0);
    check("abort_busy", BUSY, 0);
    check("abort_index", LUT_INDEX, 0);
    @(negedge clk) RST = 1'b0;
    run_seq(-1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
